// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM between N_REQ overlay
// requesters. One ROM read is issued per cycle at most; the returned row is
// routed back to its owner through a one-hot tag pipeline.
//
// Build option: define FONT_ARB_FIXED_PRIO_EN for fixed priority (index 0
// highest). Left undefined, the arbiter is round-robin with a rotating pointer.
//
// Handshake: req[i] is a level request. The request is accepted on the edge
// where gnt[i] rises, and gnt[i] is high for exactly one cycle. req_addr for
// requester i must stay stable while req[i] is high and gnt[i] is low. In the
// gnt cycle the requester may present a new address or drop req. The read
// result comes back as a one-cycle rvalid[i] pulse with rdata, ROM_LAT+1
// cycles after gnt[i]. There is no back-pressure on the return path.
module font_rom_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_en,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          rvalid
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    // A requester granted last cycle is masked so a held req is not served
    // twice for the same address.
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [PTR_W-1:0] sel;
    logic [PTR_W:0]   scan;

    // One stage per ROM latency edge; gnt itself is the first tag stage and
    // rvalid the last.
    logic [N_REQ-1:0] tag_pipe [ROM_LAT];

    assign eligible = req & ~gnt;

`ifndef FONT_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0] ptr;
`endif

    // Winner search: first eligible bit from the start index, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        scan  = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef FONT_ARB_FIXED_PRIO_EN
            scan = (PTR_W+1)'(i);
`else
            scan = {1'b0, ptr} + (PTR_W+1)'(i);
            if (scan >= (PTR_W+1)'(N_REQ)) begin
                scan = scan - (PTR_W+1)'(N_REQ);
            end
`endif
            if (!found && eligible[scan[PTR_W-1:0]]) begin
                found = 1'b1;
                sel   = scan[PTR_W-1:0];
            end
        end
    end

    // Issue register: grant pulse, ROM address and read enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            rom_addr <= '0;
            rom_en   <= 1'b0;
        end else if (found) begin
            gnt      <= ONE_HOT0 << sel;
            rom_addr <= req_addr[int'(sel)*ADDR_W +: ADDR_W];
            rom_en   <= 1'b1;
        end else begin
            gnt      <= '0;
            rom_en   <= 1'b0;
        end
    end

`ifndef FONT_ARB_FIXED_PRIO_EN
    // Round-robin pointer: moves to one past the winner, wrapping to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (sel == PTR_W'(N_REQ-1)) ? '0 : sel + 1'b1;
        end
    end
`endif

    // Tag pipeline: carries the grant vector alongside the read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= gnt;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    // Return register: capture ROM row when its tag arrives; hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= tag_pipe[ROM_LAT-1];
            if (|tag_pipe[ROM_LAT-1]) begin
                rdata <= rom_data;
            end
        end
    end

    // Returns are serialised one per cycle, so rvalid is never multi-hot.
    rvalid_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(rvalid));

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model of the arbiter and a behavioural ROM.
module tb_font_rom_arbiter;

  localparam int N_REQ   = 3;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 8;
  localparam int ROM_LAT = 1;
  localparam int W       = 48;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [N_REQ-1:0]         req = '0;
  logic [N_REQ*ADDR_W-1:0]  req_addr = '0;
  logic [N_REQ-1:0]         gnt;
  logic [ADDR_W-1:0]        rom_addr;
  logic                     rom_en;
  logic [DATA_W-1:0]        rom_data;
  logic [DATA_W-1:0]        rdata;
  logic [N_REQ-1:0]         rvalid;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard state
  logic [W-1:0]       exp_q[$];
  int                 cyc = 0;
  int                 m_ptr = 0;
  int                 m_last = -1;
  logic [N_REQ-1:0]   exp_gnt = '0;
  logic [ADDR_W-1:0]  exp_addr = '0;
  logic [DATA_W-1:0]  last_data = '0;

  font_rom_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .rdata(rdata), .rvalid(rvalid)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {5'b0, a[10:8]} ^ 8'h92;
  endfunction

  // behavioural synchronous ROM with ROM_LAT edges of latency
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(rom_addr);
    for (int s = 1; s < ROM_LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: decides each edge's winner from the requests seen
  initial begin
    int pick;
    int j;
    logic [ADDR_W-1:0] a;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        cyc = 0; m_ptr = 0; m_last = -1;
        exp_gnt = '0; exp_addr = '0; last_data = '0;
        exp_q.delete();
      end else begin
        cyc++;
        pick = -1;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef FONT_ARB_FIXED_PRIO_EN
          j = k;
`else
          j = (m_ptr + k) % N_REQ;
`endif
          if (pick < 0 && req[j] && j != m_last) pick = j;
        end
        exp_gnt = '0;
        if (pick >= 0) begin
          a = req_addr[pick*ADDR_W +: ADDR_W];
          exp_gnt[pick] = 1'b1;
          exp_addr = a;
          exp_q.push_back({32'(cyc + ROM_LAT + 1), 8'(pick), rom_fn(a)});
          m_ptr = (pick + 1) % N_REQ;
        end
        m_last = pick;
      end
    end
  end

  // monitor: compares DUT outputs against the model away from the clock edge
  initial begin
    logic [W-1:0]     e;
    logic [N_REQ-1:0] ov;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("rom_en", 32'(rom_en), 32'(exp_gnt != '0));
        check("rom_addr", 32'(rom_addr), 32'(exp_addr));
        if (exp_q.size() > 0 && exp_q[0][47:16] == 32'(cyc)) begin
          e = exp_q.pop_front();
          ov = '0;
          ov[e[15:8]] = 1'b1;
          last_data = e[7:0];
          check("rvalid", 32'(rvalid), 32'(ov));
          check("rdata", 32'(rdata), 32'(e[7:0]));
        end else begin
          check("rvalid_idle", 32'(rvalid), 0);
          check("rdata_hold", 32'(rdata), 32'(last_data));
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic run_random(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          set_addr(i, ADDR_W'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [N_REQ-1:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;

    // reset then idle
    do_reset();
    repeat (10) @(negedge clk);
    check("idle_gnt", 32'(gnt), 0);
    check("idle_rvalid", 32'(rvalid), 0);
    check("idle_rom_en", 32'(rom_en), 0);
    check("idle_rom_addr", 32'(rom_addr), 0);

    // single request
    req = 3'b010;
    set_addr(1, 11'h235);
    @(negedge clk);
    check("single_gnt", 32'(gnt), 32'(3'b010));
    check("single_addr", 32'(rom_addr), 32'h235);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("single_rvalid", 32'(rvalid), 32'(3'b010));
    check("single_rdata", 32'(rdata), 32'hA5);

    // contention: all three held
    do_reset();
    set_addr(0, 11'h010); set_addr(1, 11'h020); set_addr(2, 11'h030);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifndef FONT_ARB_FIXED_PRIO_EN
      check("rr_order", 32'(gnt), 32'(seq[k]));
`endif
    end
    req = '0;
    repeat (4) @(negedge clk);

    // withdraw and wrap
    do_reset();
    req = 3'b100;
    set_addr(2, 11'h7FF);
    @(negedge clk);
    req = 3'b001;
    set_addr(0, 11'h000);
    @(negedge clk);
`ifndef FONT_ARB_FIXED_PRIO_EN
    check("wrap_gnt", 32'(gnt), 32'(3'b001));
`endif
    req = 3'b011;
    set_addr(1, 11'h155);
    @(negedge clk);
    req = 3'b000;
    repeat (4) @(negedge clk);

    // reset while a read is in flight
    do_reset();
    req = 3'b100;
    set_addr(2, 11'h3C3);
    @(negedge clk);
    check("mid_gnt", 32'(gnt), 32'(3'b100));
    req = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_rom_en", 32'(rom_en), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

`ifdef FONT_ARB_FIXED_PRIO_EN
    // fixed priority: lowest index wins the next free cycle
    do_reset();
    set_addr(0, 11'h001); set_addr(1, 11'h002); set_addr(2, 11'h004);
    req = 3'b110;
    @(negedge clk);
    check("fp_first", 32'(gnt), 32'(3'b010));
    req = 3'b111;
    @(negedge clk);
    check("fp_second", 32'(gnt), 32'(3'b001));
    req = '0;
    repeat (4) @(negedge clk);
`endif

    // random traffic
    do_reset();
    run_random(3000);
    req = '0;
    repeat (8) @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
